// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding imem read handshake, stale-fetch discard.
// Optional memory timeout with sticky FAULT state when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        pc_write,
    input  logic [9:0]  pc_w_data,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [19:0] imem_rdata,
    output logic [19:0] instruction,
    output logic        instr_valid,
    output logic [9:0]  pc_out,
    output logic        pc_overflow,
    output logic        fetch_fault
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQUEST, FAULT} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`else
    typedef enum logic [0:0] {IDLE, REQUEST} state_t;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign fetch_fault = 1'b0;
`endif

    state_t state;
    logic   stale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_out      <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc_overflow <= 1'b0;
            stale       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_fault <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // pc_write wins; a coincident fetch is dropped
                    if (pc_write) begin
                        pc_out      <= pc_w_data;
                        instr_valid <= 1'b0;
                        pc_overflow <= 1'b0;
                    end else if (fetch) begin
                        state       <= REQUEST;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_out;
                        instr_valid <= 1'b0;
                        stale       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                REQUEST: begin
                    if (pc_write) begin
                        pc_out      <= pc_w_data;
                        pc_overflow <= 1'b0;
                    end
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                        stale    <= 1'b0;
                        // data is only kept if no PC redirect touched this fetch
                        if (!pc_write && !stale) begin
                            instruction <= imem_rdata;
                            instr_valid <= 1'b1;
                            pc_out      <= pc_out + 10'd1;
                            if (pc_out == 10'h3FF) pc_overflow <= 1'b1;
                        end
                    end else begin
                        if (pc_write) stale <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            state       <= FAULT;
                            imem_req    <= 1'b0;
                            fetch_fault <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + CW'(1);
                        end
`endif
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                FAULT: ;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_fetch_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch = 1'b0, pc_write = 1'b0, imem_ack = 1'b0;
    logic [9:0]  pc_w_data = '0;
    logic [19:0] imem_rdata = '0;
    logic        imem_req, instr_valid, pc_overflow, fetch_fault;
    logic [9:0]  imem_addr, pc_out;
    logic [19:0] instruction;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .pc_write(pc_write), .pc_w_data(pc_w_data),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .pc_out(pc_out),
        .pc_overflow(pc_overflow), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch is either outstanding (busy) or not; a redirect poisons it.
    int  m_pc, m_addr, m_instr, m_wait;
    bit  m_busy, m_stale, m_valid, m_ovf, m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 0; m_addr <= 0; m_instr <= 0; m_wait <= 0;
            m_busy <= 0; m_stale <= 0; m_valid <= 0; m_ovf <= 0; m_fault <= 0;
        end else if (m_fault) begin
        end else if (!m_busy) begin
            if (pc_write) begin
                m_pc <= int'(pc_w_data); m_valid <= 0; m_ovf <= 0;
            end else if (fetch) begin
                m_busy <= 1; m_addr <= m_pc; m_valid <= 0; m_stale <= 0; m_wait <= 0;
            end
        end else begin
            if (pc_write) begin
                m_pc <= int'(pc_w_data); m_ovf <= 0;
            end
            if (imem_ack) begin
                m_busy <= 0; m_stale <= 0;
                if (!pc_write && !m_stale) begin
                    m_instr <= int'(imem_rdata);
                    m_valid <= 1;
                    m_pc    <= (m_pc + 1) % 1024;
                    if (m_pc + 1 >= 1024) m_ovf <= 1;
                end
            end else begin
                if (pc_write) m_stale <= 1;
`ifdef FETCH_TIMEOUT_EN
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= TO) begin
                    m_busy <= 0; m_fault <= 1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_req",   32'(imem_req),    32'(m_busy));
        chk("cmp_valid", 32'(instr_valid), 32'(m_valid));
        chk("cmp_pc",    32'(pc_out),      32'(m_pc));
        chk("cmp_ovf",   32'(pc_overflow), 32'(m_ovf));
        chk("cmp_fault", 32'(fetch_fault), 32'(m_fault));
        chk("cmp_instr", 32'(instruction), 32'(m_instr));
        if (m_busy) chk("cmp_addr", 32'(imem_addr), 32'(m_addr));
    end

    // Apply one cycle of inputs, then return shortly after the edge with inputs idle.
    task automatic cyc(input bit f, input bit pw, input logic [9:0] d, input bit a, input logic [19:0] rd);
        fetch = f; pc_write = pw; pc_w_data = d; imem_ack = a; imem_rdata = rd;
        @(posedge clk); #2;
        fetch = 0; pc_write = 0; pc_w_data = '0; imem_ack = 0; imem_rdata = '0;
    endtask

    task automatic idle(); cyc(0, 0, 10'd0, 0, 20'd0); endtask

    logic [11:0] wide_pc;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instruction), 0);
        chk("rst_ovf", 32'(pc_overflow), 0);
        chk("rst_fault", 32'(fetch_fault), 0);
        rst_n = 1'b1;

        // basic fetch, ack on the third cycle after the request
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("f1_req", 32'(imem_req), 1);
        chk("f1_addr", 32'(imem_addr), 0);
        idle(); idle();
        chk("f1_hold_req", 32'(imem_req), 1);
        chk("f1_hold_addr", 32'(imem_addr), 0);
        cyc(0, 0, 10'd0, 1, 20'hABCDE);
        chk("f1_instr", 32'(instruction), 32'h000ABCDE);
        chk("f1_valid", 32'(instr_valid), 1);
        chk("f1_pc", 32'(pc_out), 1);
        chk("f1_req_drop", 32'(imem_req), 0);
        idle();
        chk("f1_valid_hold", 32'(instr_valid), 1);

        // wrap from 1023
        cyc(0, 1, 10'd1023, 0, 20'd0);
        chk("w_pc", 32'(pc_out), 1023);
        chk("w_valid_clr", 32'(instr_valid), 0);
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("w_addr", 32'(imem_addr), 1023);
        cyc(0, 0, 10'd0, 1, 20'h11111);
        chk("w_pc0", 32'(pc_out), 0);
        chk("w_ovf", 32'(pc_overflow), 1);
        idle();
        chk("w_ovf_sticky", 32'(pc_overflow), 1);
        cyc(0, 1, 10'd5, 0, 20'd0);
        chk("w_ovf_clr", 32'(pc_overflow), 0);
        chk("w_pc5", 32'(pc_out), 5);

        // redirect while a fetch is outstanding
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("s_addr", 32'(imem_addr), 5);
        wide_pc = 12'h040;
        cyc(0, 1, wide_pc[9:0], 0, 20'd0);
        chk("s_pc", 32'(pc_out), 32'h40);
        chk("s_req_hold", 32'(imem_req), 1);
        chk("s_addr_hold", 32'(imem_addr), 5);
        cyc(0, 0, 10'd0, 1, 20'h12345);
        chk("s_valid", 32'(instr_valid), 0);
        chk("s_pc_keep", 32'(pc_out), 32'h40);
        chk("s_instr_keep", 32'(instruction), 32'h11111);
        chk("s_req_drop", 32'(imem_req), 0);
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("s_next_addr", 32'(imem_addr), 32'h40);
        cyc(0, 0, 10'd0, 1, 20'h0BEEF);
        chk("s_next_pc", 32'(pc_out), 32'h41);

        // fetch and pc_write together in IDLE
        cyc(1, 1, 10'd7, 0, 20'd0);
        chk("fw_req", 32'(imem_req), 0);
        chk("fw_pc", 32'(pc_out), 7);

        // stray ack in IDLE, fetch in REQUEST, write coincident with ack
        cyc(0, 0, 10'd0, 1, 20'h55555);
        chk("ia_valid", 32'(instr_valid), 0);
        chk("ia_pc", 32'(pc_out), 7);
        cyc(1, 0, 10'd0, 0, 20'd0);
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("rf_addr", 32'(imem_addr), 7);
        cyc(0, 1, 10'd3, 1, 20'h77777);
        chk("wa_valid", 32'(instr_valid), 0);
        chk("wa_pc", 32'(pc_out), 3);
        chk("wa_req", 32'(imem_req), 0);

        // reset in the middle of a request, then a late ack
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("r_req", 32'(imem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("r_async_req", 32'(imem_req), 0);
        chk("r_async_pc", 32'(pc_out), 0);
        idle();
        rst_n = 1'b1;
        cyc(0, 0, 10'd0, 1, 20'h99999);
        chk("r_valid", 32'(instr_valid), 0);
        chk("r_pc", 32'(pc_out), 0);
        chk("r_instr", 32'(instruction), 0);
        chk("r_addr", 32'(imem_addr), 0);
        chk("r_ovf", 32'(pc_overflow), 0);

`ifdef FETCH_TIMEOUT_EN
        cyc(1, 0, 10'd0, 0, 20'd0);
        idle(); idle(); idle();
        chk("t_wait_req", 32'(imem_req), 1);
        chk("t_wait_fault", 32'(fetch_fault), 0);
        idle();
        chk("t_fault", 32'(fetch_fault), 1);
        chk("t_req", 32'(imem_req), 0);
        cyc(1, 0, 10'd0, 0, 20'd0);
        chk("t_fetch_ign", 32'(imem_req), 0);
        cyc(0, 1, 10'd9, 0, 20'd0);
        chk("t_pw_ign", 32'(pc_out), 0);
        rst_n = 1'b0;
        #1;
        chk("t_rst_clr", 32'(fetch_fault), 0);
        idle();
        rst_n = 1'b1;
        idle();
`endif

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
